// File: rtl/rr_stage_arb.sv
// Round-robin arbiter feeding one shared valid/ready register stage.
// The winning requester's beat is captured with its source index and held under backpressure.
module rr_stage_arb #(
  parameter int N = 4,
  parameter int W = 32,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           arst,
  input  logic [N-1:0]   in_vld,
  input  logic [N*W-1:0] in_dat,
  output logic [N-1:0]   in_rdy,
  output logic           out_vld,
  output logic [W-1:0]   out_dat,
  output logic [SW-1:0]  out_src,
  input  logic           out_rdy
);

  logic           out_vld_q, out_vld_d;
  logic [W-1:0]   out_dat_q, out_dat_d;
  logic [SW-1:0]  out_src_q, out_src_d;
  logic [SW-1:0]  ptr_q, ptr_d;

  logic [2*N-1:0] vld_rot;
  logic           found;
  logic [SW-1:0]  off;
  logic [SW:0]    sum;
  logic [SW-1:0]  win;
  logic [N-1:0]   gnt;
  logic [W-1:0]   sel_dat;
  logic           load;
  logic           xfer;

  // Rotate the request vector so the search always starts at bit 0, then map back.
  always_comb begin
    vld_rot = {in_vld, in_vld} >> ptr_q;
    found   = 1'b0;
    off     = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && vld_rot[k]) begin
        found = 1'b1;
        off   = SW'(k);
      end
    end
    sum = {1'b0, ptr_q} + {1'b0, off};
    win = (sum >= (SW+1)'(N)) ? SW'(sum - (SW+1)'(N)) : SW'(sum);
    gnt = found ? (N'(1) << win) : '0;
  end

  assign load   = !out_vld_q || out_rdy;
  assign in_rdy = gnt & {N{load & ~arst}};
  assign xfer   = |in_rdy;

  always_comb begin
    sel_dat = '0;
    for (int i = 0; i < N; i++) begin
      sel_dat = sel_dat | (in_dat[i*W +: W] & {W{gnt[i]}});
    end
  end

  always_comb begin
    out_vld_d = out_vld_q;
    out_dat_d = out_dat_q;
    out_src_d = out_src_q;
    ptr_d     = ptr_q;
    if (xfer) begin
      out_vld_d = 1'b1;
      out_dat_d = sel_dat;
      out_src_d = win;
      ptr_d     = (win == SW'(N-1)) ? '0 : win + 1'b1;
    end else if (out_rdy) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
      out_src_q <= '0;
      ptr_q     <= '0;
    end else begin
      out_vld_q <= out_vld_d;
      out_dat_q <= out_dat_d;
      out_src_q <= out_src_d;
      ptr_q     <= ptr_d;
    end
  end

  assign out_vld = out_vld_q;
  assign out_dat = out_dat_q;
  assign out_src = out_src_q;

`ifndef SYNTHESIS
  a_rdy_onehot: assert property (@(posedge clk) disable iff (arst) $onehot0(in_rdy));
  a_rdy_has_vld: assert property (@(posedge clk) disable iff (arst) (in_rdy & ~in_vld) == '0);
  a_hold_stall: assert property (@(posedge clk) disable iff (arst)
    (out_vld_q && !out_rdy) |=> (out_vld_q && $stable(out_dat_q) && $stable(out_src_q)));
`endif

endmodule

// File: tb/tb_rr_stage_arb.sv
// Bench for rr_stage_arb: directed vector table, reset sequence, and a randomized
// run checked against a queue-based reference model and per-source scoreboard.
module tb_rr_stage_arb;

  localparam int N = 4;
  localparam int W = 32;
  localparam logic [31:0] D0 = 32'h0000_0000;
  localparam logic [31:0] D1 = 32'hFFFF_FFFF;
  localparam logic [31:0] D2 = 32'hA5A5_A5A5;
  localparam logic [31:0] D3 = 32'h1234_5678;

  logic           clk;
  logic           arst;
  logic [N-1:0]   in_vld;
  logic [N*W-1:0] in_dat;
  logic [N-1:0]   in_rdy;
  logic           out_vld;
  logic [W-1:0]   out_dat;
  logic [1:0]     out_src;
  logic           out_rdy;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic [3:0]  vld;
    logic        ordy;
    logic [3:0]  exp_rdy;
    logic        exp_ovld;
    logic [1:0]  exp_src;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vecs[$];

  // Reference model state: output stage, rotation pointer and requester bookkeeping.
  logic        m_vld;
  logic [31:0] m_dat;
  int          m_src;
  int          m_ptr;
  bit          pend[N];
  logic [31:0] beat[N];
  int          wait_cnt[N];
  logic [31:0] sb_q[N][$];

  rr_stage_arb #(.N(N), .W(W)) dut (
    .clk     (clk),
    .arst    (arst),
    .in_vld  (in_vld),
    .in_dat  (in_dat),
    .in_rdy  (in_rdy),
    .out_vld (out_vld),
    .out_dat (out_dat),
    .out_src (out_src),
    .out_rdy (out_rdy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic apply_stimulus(input logic [3:0] vld, input logic ordy);
    @(negedge clk);
    in_vld  = vld;
    out_rdy = ordy;
    #1;
  endtask

  task automatic check_output(input string tag, input logic ovld, input logic [1:0] src,
                              input logic [31:0] dat);
    @(posedge clk);
    #1;
    check({tag, " out_vld"}, {31'd0, out_vld}, {31'd0, ovld});
    check({tag, " out_src"}, {30'd0, out_src}, {30'd0, src});
    check({tag, " out_dat"}, out_dat, dat);
  endtask

  task automatic do_reset();
    @(negedge clk);
    arst    = 1'b1;
    in_vld  = '0;
    out_rdy = 1'b0;
    repeat (2) @(negedge clk);
    arst = 1'b0;
  endtask

  // First requester at or after the pointer, wrapping; -1 when nothing may load.
  function automatic int model_winner(input logic ordy);
    int w;
    w = -1;
    if (!m_vld || ordy) begin
      for (int k = 0; k < N; k++) begin
        if (w < 0 && pend[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      end
    end
    return w;
  endfunction

  task automatic rand_cycle(input bit draining);
    int          w;
    logic [3:0]  exp_rdy;
    logic [31:0] front;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && !draining && $urandom_range(0, 99) < 50) begin
        pend[i]     = 1'b1;
        beat[i]     = $urandom;
        wait_cnt[i] = 0;
      end
      in_vld[i]         = pend[i];
      in_dat[i*W +: W]  = beat[i];
    end
    out_rdy = draining ? 1'b1 : ($urandom_range(0, 99) < 70);
    #1;
    w       = model_winner(out_rdy);
    exp_rdy = (w >= 0) ? (4'b0001 << w) : 4'b0000;
    check("rand in_rdy", {28'd0, in_rdy}, {28'd0, exp_rdy});

    if (m_vld && out_rdy) begin
      check("sb beat present", {31'd0, sb_q[out_src].size() > 0}, 32'd1);
      if (sb_q[out_src].size() > 0) begin
        front = sb_q[out_src].pop_front();
        check("sb per-source order", out_dat, front);
      end
    end

    if (w >= 0) begin
      sb_q[w].push_back(beat[w]);
      check("fairness wait", {31'd0, wait_cnt[w] <= N - 1}, 32'd1);
      for (int i = 0; i < N; i++) begin
        if (i != w && pend[i]) wait_cnt[i]++;
      end
      pend[w] = 1'b0;
      m_vld   = 1'b1;
      m_dat   = beat[w];
      m_src   = w;
      m_ptr   = (w + 1) % N;
    end else if (out_rdy) begin
      m_vld = 1'b0;
    end

    @(posedge clk);
    #1;
    check("rand out_vld", {31'd0, out_vld}, {31'd0, m_vld});
    if (m_vld) begin
      check("rand out_src", {30'd0, out_src}, 32'(m_src));
      check("rand out_dat", out_dat, m_dat);
    end
  endtask

  initial begin
    arst    = 1'b1;
    in_vld  = '0;
    out_rdy = 1'b0;
    in_dat  = {D3, D2, D1, D0};

    // vld, out_rdy, expected in_rdy, then expected stage contents after the edge
    vecs.push_back('{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, D0});
    vecs.push_back('{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, D1});
    vecs.push_back('{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, D2});
    vecs.push_back('{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, D3});
    vecs.push_back('{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, D0});
    vecs.push_back('{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, D1});
    vecs.push_back('{4'b1101, 1'b1, 4'b0100, 1'b1, 2'd2, D2});
    vecs.push_back('{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, D3});
    vecs.push_back('{4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, D0});
    vecs.push_back('{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, D2});
    vecs.push_back('{4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0, D0});
    vecs.push_back('{4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2, D2});
    vecs.push_back('{4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0, D0});
    vecs.push_back('{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, D2});
    vecs.push_back('{4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, D3});
    vecs.push_back('{4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, D3});
    vecs.push_back('{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, D3});
    vecs.push_back('{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, D1});
    vecs.push_back('{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, D1});
    vecs.push_back('{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, D3});
    for (int s = 0; s < 5; s++) vecs.push_back('{4'b0111, 1'b0, 4'b0000, 1'b1, 2'd3, D3});
    vecs.push_back('{4'b0111, 1'b1, 4'b0001, 1'b1, 2'd0, D0});
    vecs.push_back('{4'b0110, 1'b1, 4'b0010, 1'b1, 2'd1, D1});
    vecs.push_back('{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, D2});
    vecs.push_back('{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, D2});

    $display("[TB] reset state");
    repeat (2) @(negedge clk);
    arst = 1'b0;
    #1;
    check("reset out_vld", {31'd0, out_vld}, 32'd0);
    check("reset out_src", {30'd0, out_src}, 32'd0);
    check("reset out_dat", out_dat, 32'd0);

    $display("[TB] directed vector table");
    for (int r = 0; r < vecs.size(); r++) begin
      apply_stimulus(vecs[r].vld, vecs[r].ordy);
      check($sformatf("vec%0d in_rdy", r), {28'd0, in_rdy}, {28'd0, vecs[r].exp_rdy});
      check_output($sformatf("vec%0d", r), vecs[r].exp_ovld, vecs[r].exp_src, vecs[r].exp_dat);
    end

    $display("[TB] asynchronous reset mid-stream");
    apply_stimulus(4'b0010, 1'b0);
    check("prereset in_rdy", {28'd0, in_rdy}, 32'h2);
    check_output("prereset", 1'b1, 2'd1, D1);
    @(negedge clk);
    arst    = 1'b1;
    out_rdy = 1'b1;
    #1;
    check("arst out_vld", {31'd0, out_vld}, 32'd0);
    check("arst out_src", {30'd0, out_src}, 32'd0);
    check("arst out_dat", out_dat, 32'd0);
    check("arst in_rdy", {28'd0, in_rdy}, 32'd0);
    @(posedge clk);
    #1;
    check("arst held out_vld", {31'd0, out_vld}, 32'd0);
    @(negedge clk);
    arst   = 1'b0;
    in_vld = 4'b1101;
    #1;
    check("postreset in_rdy", {28'd0, in_rdy}, 32'h1);
    check_output("postreset", 1'b1, 2'd0, D0);

    $display("[TB] randomized run");
    do_reset();
    m_vld = 1'b0;
    m_dat = '0;
    m_src = 0;
    m_ptr = 0;
    for (int i = 0; i < N; i++) begin
      pend[i]     = 1'b0;
      beat[i]     = '0;
      wait_cnt[i] = 0;
    end
    #1;
    check("rand reset out_vld", {31'd0, out_vld}, 32'd0);
    for (int c = 0; c < 10000; c++) rand_cycle(1'b0);
    for (int c = 0; c < 12; c++) rand_cycle(1'b1);
    check("drain out_vld", {31'd0, out_vld}, 32'd0);
    for (int i = 0; i < N; i++) begin
      check($sformatf("sb leftover src%0d", i), 32'(sb_q[i].size()), 32'd0);
      check($sformatf("pending src%0d", i), {31'd0, pend[i]}, 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
